// File: rtl/fetch_queue_if.sv
// rtl/fetch_queue_if.sv - fetch queue handshake bundle between IF, ID and the queue
//
// Signals:
//   push, in_ir, in_pc4   IF side: instruction word and its PC+4 offered to the queue
//   full                  queue holds DEPTH entries; IF PC enable is ~full
//   pop                   ID consumes the head entry
//   out_valid, out_ir,    head entry; ir/pc4 read as zero when out_valid=0
//   out_pc4
//   flush                 branch/jump redirect, discards all entries
//   count                 stored entries, 0..DEPTH
// Modports: master = pipeline (IF/ID) side, slave = queue side.
interface fetch_queue_if #(
  parameter int AW = 2
);
  logic          push;
  logic [31:0]   in_ir;
  logic [31:0]   in_pc4;
  logic          full;
  logic          pop;
  logic          out_valid;
  logic [31:0]   out_ir;
  logic [31:0]   out_pc4;
  logic          flush;
  logic [AW:0]   count;

  modport master (
    output push, in_ir, in_pc4, pop, flush,
    input  full, out_valid, out_ir, out_pc4, count
  );

  modport slave (
    input  push, in_ir, in_pc4, pop, flush,
    output full, out_valid, out_ir, out_pc4, count
  );
endinterface

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - instruction prefetch FIFO between the IF and ID pipeline stages
//
// Ports:
//   clk    rising-edge pipeline clock
//   reset  asynchronous active-high reset, discards all entries
//   bus    fetch_queue_if.slave: push/in_ir/in_pc4, full, pop, out_valid/out_ir/out_pc4,
//          flush, count
// Optional feature: define FETCHQ_BYPASS_EN to present a push into an empty queue on
// the outputs in the same cycle (0-cycle latency); a same-cycle pop consumes it without
// it ever being written.
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input logic          clk,
  input logic          reset,
  fetch_queue_if.slave bus
);
  logic [63:0]   mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   cnt;

  logic        stored_valid;
  logic        push_ok;
  logic        pop_ok;
  logic        wr_en;
  logic        bypass;
  logic        bypass_pop;
  logic [63:0] head;

  assign stored_valid = (cnt != '0);
  assign bus.full     = (cnt == (AW+1)'(DEPTH));
  assign bus.count    = cnt;

  assign push_ok = bus.push & ~bus.full;
  // Pops only ever release stored entries; a bypassed entry is consumed separately.
  assign pop_ok  = bus.pop & stored_valid;

`ifdef FETCHQ_BYPASS_EN
  assign bypass     = ~stored_valid & bus.push & ~bus.flush;
  assign bypass_pop = bypass & bus.pop;
`else
  assign bypass     = 1'b0;
  assign bypass_pop = 1'b0;
`endif

  // An entry handed straight to decode must not also be stored.
  assign wr_en = push_ok & ~bypass_pop;

  assign head = bypass ? {bus.in_ir, bus.in_pc4} : mem[rd_ptr];

  always_comb begin
    bus.out_valid = stored_valid | bypass;
    bus.out_ir    = '0;
    bus.out_pc4   = '0;
    if (stored_valid | bypass) begin
      bus.out_ir  = head[63:32];
      bus.out_pc4 = head[31:0];
    end
  end

  // Storage carries no reset; its contents are meaningless while cnt says empty.
  always_ff @(posedge clk) begin
    if (!bus.flush && wr_en) begin
      mem[wr_ptr] <= {bus.in_ir, bus.in_pc4};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else if (bus.flush) begin
      // Anything pushed alongside a redirect is on the wrong path.
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
      if (wr_en) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({wr_en, pop_ok})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end
endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - self-checking bench for fetch_queue with a queue-based reference model
module tb_fetch_queue;
  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic clk;
  logic reset;
  int   tests;
  int   fails;
  bit   run_cmp;

  logic [63:0] q[$];

  fetch_queue_if #(.AW(AW)) bus ();

  fetch_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

`ifdef FETCHQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue of {ir, pc4}; updated at each edge from the applied inputs.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      q.delete();
    end else if (bus.flush) begin
      q.delete();
    end else begin
      bit can_push;
      bit direct;
      can_push = bus.push && (q.size() < DEPTH);
      direct   = BYP && (q.size() == 0) && bus.push && bus.pop;
      if (bus.pop && q.size() != 0) void'(q.pop_front());
      if (can_push && !direct) q.push_back({bus.in_ir, bus.in_pc4});
    end
  end

  // Compare process: every negedge, outputs must match what the model's contents imply.
  always @(negedge clk) begin
    if (run_cmp) begin
      logic        ev;
      logic [63:0] eh;
      ev = 1'b0;
      eh = '0;
      if (q.size() != 0) begin
        ev = 1'b1;
        eh = q[0];
      end else if (BYP && bus.push && !bus.flush) begin
        ev = 1'b1;
        eh = {bus.in_ir, bus.in_pc4};
      end
      chk("cmp_count", 32'(bus.count), 32'(q.size()));
      chk("cmp_full", 32'(bus.full), 32'(q.size() == DEPTH));
      chk("cmp_valid", 32'(bus.out_valid), 32'(ev));
      chk("cmp_ir", bus.out_ir, eh[63:32]);
      chk("cmp_pc4", bus.out_pc4, eh[31:0]);
    end
  end

  // Apply inputs for one cycle, pass the edge, then return to idle.
  task automatic step(input bit p, input logic [31:0] ir, input logic [31:0] pc4,
                      input bit po, input bit fl);
    bus.push   = p;
    bus.in_ir  = ir;
    bus.in_pc4 = pc4;
    bus.pop    = po;
    bus.flush  = fl;
    @(posedge clk);
    #1;
    bus.push   = 1'b0;
    bus.in_ir  = '0;
    bus.in_pc4 = '0;
    bus.pop    = 1'b0;
    bus.flush  = 1'b0;
  endtask

  initial begin
    tests      = 0;
    fails      = 0;
    run_cmp    = 1'b0;
    reset      = 1'b1;
    bus.push   = 1'b0;
    bus.in_ir  = '0;
    bus.in_pc4 = '0;
    bus.pop    = 1'b0;
    bus.flush  = 1'b0;
    #1;
    chk("rst_count", 32'(bus.count), 32'd0);
    chk("rst_full", 32'(bus.full), 32'd0);
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_ir", bus.out_ir, 32'd0);
    chk("rst_pc4", bus.out_pc4, 32'd0);
    @(posedge clk);
    #1;
    reset   = 1'b0;
    run_cmp = 1'b1;

    // 1: single push, visible the next cycle
    step(1, 32'h3c011234, 32'h00003004, 0, 0);
    chk("t1_valid", 32'(bus.out_valid), 32'd1);
    chk("t1_ir", bus.out_ir, 32'h3c011234);
    chk("t1_pc4", bus.out_pc4, 32'h00003004);
    chk("t1_count", 32'(bus.count), 32'd1);
    step(0, 0, 0, 1, 0);
    chk("t1_drained", 32'(bus.count), 32'd0);

    // 2: fill, overflow push dropped, drain in order
    for (int i = 0; i < 4; i++) step(1, 32'h20000000 + i, 32'h00003004 + 4 * i, 0, 0);
    chk("t2_full", 32'(bus.full), 32'd1);
    chk("t2_count", 32'(bus.count), 32'd4);
    step(1, 32'h2000ffff, 32'h00003014, 0, 0);
    chk("t2_count_ovf", 32'(bus.count), 32'd4);
    chk("t2_pop0", bus.out_pc4, 32'h00003004);
    step(0, 0, 0, 1, 0);
    chk("t2_pop1", bus.out_pc4, 32'h00003008);
    step(0, 0, 0, 1, 0);
    chk("t2_pop2", bus.out_pc4, 32'h0000300c);
    step(0, 0, 0, 1, 0);
    chk("t2_pop3", bus.out_pc4, 32'h00003010);
    chk("t2_ir3", bus.out_ir, 32'h20000003);
    step(0, 0, 0, 1, 0);
    chk("t2_empty_valid", 32'(bus.out_valid), 32'd0);
    chk("t2_empty_ir", bus.out_ir, 32'd0);
    step(0, 0, 0, 1, 0);
    chk("t2_pop_empty", 32'(bus.count), 32'd0);

    // 3: steady push+pop stream across pointer wrap
    step(1, 32'h24000000, 32'h00004000, 0, 0);
    for (int i = 1; i <= 10; i++) begin
      step(1, 32'h24000000 + i, 32'h00004000 + 4 * i, 1, 0);
      chk("t3_count", 32'(bus.count), 32'd1);
      chk("t3_pc4", bus.out_pc4, 32'h00004000 + 4 * i);
    end
    step(0, 0, 0, 1, 0);

    // 4: flush with push+pop at three entries
    for (int i = 0; i < 3; i++) step(1, 32'h28000000 + i, 32'h00005000 + 4 * i, 0, 0);
    chk("t4_pre", 32'(bus.count), 32'd3);
    step(1, 32'h2800ffff, 32'h0000500c, 1, 1);
    chk("t4_count", 32'(bus.count), 32'd0);
    chk("t4_valid", 32'(bus.out_valid), 32'd0);
    chk("t4_full", 32'(bus.full), 32'd0);
    step(1, 32'h2c000000, 32'h00003100, 0, 0);
    chk("t4_next", bus.out_pc4, 32'h00003100);
    step(0, 0, 0, 1, 0);

    // 5: asynchronous reset between edges
    step(1, 32'h30000000, 32'h00006000, 0, 0);
    step(1, 32'h30000001, 32'h00006004, 0, 0);
    chk("t5_pre", 32'(bus.count), 32'd2);
    #1;
    reset = 1'b1;
    #1;
    chk("t5_count", 32'(bus.count), 32'd0);
    chk("t5_valid", 32'(bus.out_valid), 32'd0);
    #1;
    reset = 1'b0;

    // 6: push+pop into an empty queue
    bus.push   = 1'b1;
    bus.in_ir  = 32'h8c080000;
    bus.in_pc4 = 32'h00007004;
    bus.pop    = 1'b1;
    #1;
    chk("t6_valid", 32'(bus.out_valid), 32'(BYP));
    chk("t6_ir", bus.out_ir, BYP ? 32'h8c080000 : 32'd0);
    @(posedge clk);
    #1;
    bus.push = 1'b0;
    bus.pop  = 1'b0;
    chk("t6_count", 32'(bus.count), BYP ? 32'd0 : 32'd1);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0);

    run_cmp = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
